// File: rtl/rim_pkg.sv
// Shared maze definitions: grid size, cell coordinates, move codes and checker
// error codes. The maze solver uses the same definitions.
package rim_pkg;

  localparam int unsigned MAZE_DIM = 8;
  localparam int unsigned COORD_W  = $clog2(MAZE_DIM);
  localparam int unsigned CELL_CNT = MAZE_DIM * MAZE_DIM;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_BAD_START = 3'd1,
    ERR_NON_ADJ   = 3'd2,
    ERR_REVISIT   = 3'd3,
    ERR_OVERFLOW  = 3'd4,
    ERR_BAD_END   = 3'd5
  } err_e;

  typedef struct packed {
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
  } cell_t;

  // Row-major position of a cell in the visited map.
  function automatic logic [2*COORD_W-1:0] cell_index(input cell_t c);
    return {c.row, c.col};
  endfunction

endpackage

// File: rtl/rim_step_decode.sv
// Classifies the move between two cells: adjacent means Manhattan distance 1
// with no wrap-around at the grid edges; dir encodes the direction of that move.
module rim_step_decode
  import rim_pkg::*;
(
  input  cell_t prev,
  input  cell_t cur,
  output logic  adjacent,
  output dir_e  dir
);

  logic signed [COORD_W:0] d_row;
  logic signed [COORD_W:0] d_col;

  // Zero-extend before subtracting so 7->0 yields -7, never a wrapped +1.
  assign d_row = $signed({1'b0, cur.row}) - $signed({1'b0, prev.row});
  assign d_col = $signed({1'b0, cur.col}) - $signed({1'b0, prev.col});

  always_comb begin
    // NOTE: every output gets a default first so no path through the block can infer a latch.
    adjacent = 1'b0;
    dir      = DIR_UP;
    if (d_col == '0 && d_row == -4'sd1) begin
      adjacent = 1'b1;
      dir      = DIR_UP;
    end else if (d_row == '0 && d_col == 4'sd1) begin
      adjacent = 1'b1;
      dir      = DIR_RIGHT;
    end else if (d_col == '0 && d_row == 4'sd1) begin
      adjacent = 1'b1;
      dir      = DIR_DOWN;
    end else if (d_row == '0 && d_col == -4'sd1) begin
      adjacent = 1'b1;
      dir      = DIR_LEFT;
    end
  end

endmodule

// File: rtl/rim_path_checker.sv
// Checks a maze-solver path streamed one cell per cycle: legal start, unit
// steps, no revisits, bounded length and legal end; reports moves and a verdict.
module rim_path_checker
  import rim_pkg::*;
#(
  parameter int unsigned START_ROW = 0,
  parameter int unsigned START_COL = 0,
  parameter int unsigned END_ROW   = 7,
  parameter int unsigned END_COL   = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [2:0] in_row,
  input  logic [2:0] in_col,
  output logic       dir_valid,
  output logic [1:0] dir,
  output logic       done,
  output logic [6:0] path_len,
  output logic       path_ok,
  output logic [2:0] err
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  localparam cell_t      START_CELL = '{row: COORD_W'(START_ROW), col: COORD_W'(START_COL)};
  localparam cell_t      END_CELL   = '{row: COORD_W'(END_ROW),   col: COORD_W'(END_COL)};
  localparam logic [6:0] MAX_LEN    = 7'(CELL_CNT);

  state_e                 state;
  cell_t                  prev;
  cell_t                  cur;
  logic [CELL_CNT-1:0]    visited;
  err_e                   err_q;
  logic                   adjacent;
  dir_e                   step_dir;
  logic [2*COORD_W-1:0]   cur_idx;

  assign cur     = '{row: in_row, col: in_col};
  assign cur_idx = cell_index(cur);
  assign err     = err_q;

  rim_step_decode u_step_decode (
    .prev     (prev),
    .cur      (cur),
    .adjacent (adjacent),
    .dir      (step_dir)
  );

  // NOTE: the visited map is an ordinary register reset with everything else,
  // so a path started right after reset never sees stale bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      prev      <= '0;
      visited   <= '0;
      path_len  <= '0;
      err_q     <= ERR_NONE;
      dir_valid <= 1'b0;
      dir       <= DIR_UP;
      done      <= 1'b0;
      path_ok   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every test below sees
      // the pre-edge value of state, err_q, path_len and visited.
      dir_valid <= 1'b0;
      done      <= 1'b0;
      path_ok   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state            <= S_RUN;
            visited          <= '0;
            visited[cur_idx] <= 1'b1;
            path_len         <= 7'd1;
            prev             <= cur;
            err_q            <= (cur == START_CELL) ? ERR_NONE : ERR_BAD_START;
          end
        end
        S_RUN: begin
          if (in_valid) begin
            prev             <= cur;
            visited[cur_idx] <= 1'b1;
            if (path_len != MAX_LEN) path_len <= path_len + 7'd1;
            // Overflow outranks the step checks: the 65th cell is always a revisit.
            if (err_q == ERR_NONE) begin
              if (path_len == MAX_LEN) begin
                err_q <= ERR_OVERFLOW;
              end else if (!adjacent) begin
                err_q <= ERR_NON_ADJ;
              end else if (visited[cur_idx]) begin
                err_q <= ERR_REVISIT;
              end else begin
                dir_valid <= 1'b1;
                dir       <= step_dir;
              end
            end
          end else begin
            state   <= S_IDLE;
            done    <= 1'b1;
            path_ok <= (err_q == ERR_NONE) && (prev == END_CELL);
            if (err_q == ERR_NONE && prev != END_CELL) err_q <= ERR_BAD_END;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rim_path_checker.md
RIM_PATH_CHECKER -- requirements
Module: rim_path_checker

Interface
REQ-001 Parameter START_ROW, default 0, row of the required first coordinate.
REQ-002 Parameter START_COL, default 0, column of the required first coordinate.
REQ-003 Parameter END_ROW, default 7, row of the required last coordinate.
REQ-004 Parameter END_COL, default 7, column of the required last coordinate.
REQ-005 Port clk  input  1  rising-edge clock.
REQ-006 Port rst_n  input  1  reset, synchronous, active-low.
REQ-007 Port in_valid  input  1  coordinate qualifier from the maze solver; a contiguous high run is one path.
REQ-008 Port in_row  input  3  path cell row, sampled when in_valid=1.
REQ-009 Port in_col  input  3  path cell column, sampled when in_valid=1.
REQ-010 Port dir_valid  output  1  one-cycle strobe per accepted legal move.
REQ-011 Port dir  output  2  move code: 0 up (row-1), 1 right (col+1), 2 down (row+1), 3 left (col-1).
REQ-012 Port done  output  1  one-cycle pulse at path end.
REQ-013 Port path_len  output  7  coordinates received in the current/last path, 0..64.
REQ-014 Port path_ok  output  1  high with done when err=0.
REQ-015 Port err  output  3  first error of the path: 0 none, 1 bad start, 2 non-adjacent, 3 revisit, 4 overflow, 5 bad end.

Function
REQ-016 FSM states IDLE and RUN; IDLE->RUN on in_valid=1; RUN->IDLE on in_valid=0; no other transitions.
REQ-017 In IDLE with in_valid=1: clear the 64-bit visited map, set the visited bit of the sampled cell, set path_len=1, store the cell as previous, clear err, and set err=1 if the cell != (START_ROW,START_COL).
REQ-018 In RUN with in_valid=1: increment path_len and check the sampled cell against the previous cell.
REQ-019 Step check: exactly one of row/col differs, by exactly 1 (Manhattan distance 1); otherwise err=2.
REQ-020 Revisit check: the visited bit of the sampled cell is already set -> err=3; the check is made only when the step check passes.
REQ-021 Overflow: the 65th coordinate of a path -> err=4; path_len saturates at 64.
REQ-022 err latches the first nonzero code only; later errors do not overwrite it.
REQ-023 While err=0 and the step is legal, dir_valid=1 with the matching dir on the cycle after the sample edge (latency 1); no dir_valid once err!=0.
REQ-024 After an error, the block keeps consuming coordinates until in_valid falls; the previous cell still updates to the sampled cell.
REQ-025 End of path (RUN with in_valid=0): if err=0 and the last cell != (END_ROW,END_COL), set err=5; assert done for one cycle on the next cycle; path_ok=done&&(err==0).
REQ-026 path_len and err hold their values from done until the next path starts.
REQ-027 A new path may start on the cycle immediately after the end-of-path sample; done for the previous path is still reported correctly.
REQ-028 A path of a single coordinate ends with err=5 unless start equals end.
REQ-029 Arithmetic: unsigned 3-bit coordinates; neighbour differences use a 4-bit signed compare; no wrap-around between 0 and 7 (7->0 is non-adjacent).

Reset
REQ-030 rst_n=0 at a clock edge forces IDLE; dir_valid=0, dir=0, done=0, path_len=0, path_ok=0, err=0, visited map and previous cell cleared.
REQ-031 Reset mid-path abandons the path: no done pulse; the next in_valid is treated as a new path start.

Structure
REQ-032 Shared package rim_pkg holds the maze dimension constant 8, the direction codes and the err codes, shared with the maze solver.
REQ-033 Sub-module rim_step_decode (combinational: previous cell, current cell -> adjacent flag, dir) is used once.

Verification
REQ-034 Legal path (0,0),(0,1),(1,1),...,(7,7) of 15 cells -> 14 dir_valid strobes with correct codes, done=1, path_len=15, path_ok=1, err=0.
REQ-035 First cell (1,0) -> done with err=1, path_ok=0, zero dir_valid strobes.
REQ-036 Jump (0,1)->(0,3) mid-path, followed by a revisit -> err=2 (first error retained), dir_valid stops after the jump.
REQ-037 Sequence (0,0),(0,1),(0,0) -> err=3, path_len=3.
REQ-038 65 coordinates -> err=4, path_len=64; a path ending at (6,7) -> err=5.
REQ-039 Back-to-back paths with one idle cycle, and rst_n=0 mid-path -> correct independent results; no done pulse for the aborted path.
